exposure_accumulator: RTL and testbench

Sequential, bit-serial signed accumulator that credits operands back into a running exposure balance. It is the addition-side counterpart to the combinational borrow/overflow check on the risk path: that check subtracts, and this block adds fills/credits back into the balance. It reuses a single full-adder cell and a carry flop, one bit per cycle, and reports carry and overflow with the same conventions as the check. It sits between the order/fill decoder (upstream valid/ready) and the risk-check stage (downstream valid/ready).

---
 rtl/exposure_accumulator.sv | 134 +++++++++++++
 tb/tb_exposure_accumulator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/exposure_accumulator.sv
// exposure_accumulator: bit-serial signed accumulator that credits operands
// into a running exposure balance using one full-adder cell and a carry flop.
// Handshakes: valid/ready on the input (operand) and output (result) sides.
// Optional build macro: EXPOSURE_SATURATE_EN (clamp on overflow instead of wrap).
module exposure_accumulator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_v,
    output logic [WIDTH-1:0] balance
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_sum;
    logic [WIDTH-1:0] r_out_sum;
    logic [WIDTH-1:0] r_balance;
    logic             r_carry;
    logic             r_out_c;
    logic             r_out_v;
    logic [CW-1:0]    r_cnt;

    logic             w_a;
    logic             w_bb;
    logic             w_s;
    logic             w_cout;
    logic             w_last;
    logic             w_accept;
    logic             w_ovf;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_result;

    // Single full-adder cell on bit r_cnt; carry into it comes from the carry flop.
    assign w_a      = r_balance[r_cnt];
    assign w_bb     = r_b[r_cnt];
    assign w_s      = w_a ^ w_bb ^ r_carry;
    assign w_cout   = (w_a & w_bb) | (r_carry & (w_a ^ w_bb));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = in_valid && in_ready;

    // Partial sum enters at the top and shifts down; on the MSB cycle the
    // concatenation is the full result with bit 0 in position 0.
    assign w_shift  = {w_s, r_sum};
    // On the MSB cycle the carry flop holds the carry into the MSB cell (c_prev).
    assign w_ovf    = w_cout ^ r_carry;

`ifdef EXPOSURE_SATURATE_EN
    // Clamp toward the operand's sign when the signed add overflows.
    assign w_result = !w_ovf     ? w_shift :
                      r_b[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_result = w_shift;
`endif

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign out_sum   = r_out_sum;
    assign out_c     = r_out_c;
    assign out_v     = r_out_v;
    assign balance   = r_balance;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: accept -> serial add for WIDTH cycles -> hold until taken.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next = S_ADD;
            S_ADD:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, serial add, and result/balance commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b       <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_out_sum <= '0;
            r_out_c   <= 1'b0;
            r_out_v   <= 1'b0;
            r_balance <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_b     <= in_data;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_ADD: begin
                    r_sum   <= w_shift[WIDTH-1:1];
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_out_sum <= w_result;
                        r_out_c   <= w_cout;
                        r_out_v   <= w_ovf;
                        r_balance <= w_result;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exposure_accumulator.sv
// Directed bench for exposure_accumulator (WIDTH=4); expected values hand-computed.
module tb_exposure_accumulator;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_c;
    logic         out_v;
    logic [W-1:0] balance;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [W-1:0] exp_bal;
    int           lat;

    exposure_accumulator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .out_v     (out_v),
        .balance   (balance)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Counts posedges from the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
    endtask

    // One credit with out_ready high: offer, accept, wait, check, hand off.
    task automatic credit(input logic [W-1:0] d, input logic [W-1:0] es,
                          input logic ec, input logic ev, input string tag);
        int n;
        chk({tag, "/ready"}, {31'd0, in_ready}, 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;              // must not affect the add in flight
        wait_valid(n);
        // Result cycle begins at the WIDTH-th edge after the accept edge.
        chk({tag, "/lat"},  n, W);
        chk({tag, "/sum"},  {28'd0, out_sum}, {28'd0, es});
        chk({tag, "/c"},    {31'd0, out_c}, {31'd0, ec});
        chk({tag, "/v"},    {31'd0, out_v}, {31'd0, ev});
        chk({tag, "/bal"},  {28'd0, balance}, {28'd0, es});
        @(negedge clk);             // result handshake edge
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst/ready", {31'd0, in_ready}, 32'd0);
        chk("rst/valid", {31'd0, out_valid}, 32'd0);
        chk("rst/bal",   {28'd0, balance}, 32'd0);
        chk("rst/sum",   {28'd0, out_sum}, 32'd0);
        chk("rst/cv",    {30'd0, out_c, out_v}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst/ready", {31'd0, in_ready}, 32'd1);

        credit(4'd3, 4'd3, 1'b0, 1'b0, "single");
        credit(4'd2, 4'd5, 1'b0, 1'b0, "to5");
`ifdef EXPOSURE_SATURATE_EN
        credit(4'd4, 4'b0111, 1'b0, 1'b1, "posovf");
        credit(4'b1000, 4'b1111, 1'b0, 1'b0, "toF");
`else
        credit(4'd4, 4'b1001, 1'b0, 1'b1, "posovf");
        credit(4'b0110, 4'b1111, 1'b0, 1'b0, "toF");
`endif
        credit(4'b0001, 4'b0000, 1'b1, 1'b0, "carry");
        credit(4'b1000, 4'b1000, 1'b0, 1'b0, "to8");
`ifdef EXPOSURE_SATURATE_EN
        exp_bal = 4'b1000;
`else
        exp_bal = 4'b0111;
`endif
        credit(4'b1111, exp_bal, 1'b1, 1'b1, "negovf");

        // Back-pressure: result held in DONE while in_valid stays high.
        out_ready = 1'b0;
        in_data   = 4'd0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_data = 4'd5;             // changed after accept: no effect
        wait_valid(lat);
        chk("bp/lat", lat, W);
        chk("bp/sum", {28'd0, out_sum}, {28'd0, exp_bal});
        chk("bp/cv",  {30'd0, out_c, out_v}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp/hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp/hold_sum",   {28'd0, out_sum}, {28'd0, exp_bal});
            chk("bp/hold_ready", {31'd0, in_ready}, 32'd0);
            chk("bp/hold_bal",   {28'd0, balance}, {28'd0, exp_bal});
        end
        in_data   = 4'd0;
        out_ready = 1'b1;
        @(negedge clk);             // result handshake only
        chk("bp/after_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("bp/after_hs_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);             // operand accepted here
        chk("bp/accepted", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp2/lat", lat, W);
        chk("bp2/sum", {28'd0, out_sum}, {28'd0, exp_bal});
        @(negedge clk);

        // Reset in the middle of ADD.
        in_data  = 4'd1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst/valid", {31'd0, out_valid}, 32'd0);
        chk("midrst/bal",   {28'd0, balance}, 32'd0);
        chk("midrst/sum",   {28'd0, out_sum}, 32'd0);
        chk("midrst/ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst/ready_after", {31'd0, in_ready}, 32'd1);
        chk("midrst/still_idle",  {31'd0, out_valid}, 32'd0);
        credit(4'd5, 4'd5, 1'b0, 1'b0, "postrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
